// File: rtl/calc_dir_pila.sv
// calc_dir_pila: two-stage pipelined effective/physical address calculator
// for BP-based stack addressing. Stage 1 forms the 16-bit offset and its
// wrap flag and picks the segment; stage 2 forms the 20-bit physical
// address. Valid/ready handshakes on both sides, in-order, with at most
// two requests in flight.
module calc_dir_pila (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  modo,
    input  logic [15:0] bp,
    input  logic [15:0] si,
    input  logic [15:0] di,
    input  logic [15:0] ss,
    input  logic        seg_ovr_en,
    input  logic [15:0] seg_ovr,
    input  logic [15:0] disp,
    input  logic        disp8,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] ea,
    output logic [19:0] dir_fis,
    output logic        ea_wrap
);

    // Displacement widened to 19 signed bits; BP-only mode ignores it.
    function automatic logic [18:0] disp_ext(input logic [15:0] d,
                                             input logic        d8,
                                             input logic [1:0]  m);
        logic [18:0] r;
        r = 19'h00000;
        case (m)
            2'b11:   r = 19'h00000;
            default: begin
                if (d8) begin
                    r = {{11{d[7]}}, d[7:0]};
                end else begin
                    r = {{3{d[15]}}, d};
                end
            end
        endcase
        return r;
    endfunction

    // Index register selected by the addressing mode.
    function automatic logic [15:0] idx_sel(input logic [1:0]  m,
                                            input logic [15:0] s,
                                            input logic [15:0] d);
        logic [15:0] r;
        r = 16'h0000;
        case (m)
            2'b01:   r = s;
            2'b10:   r = d;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Real-mode physical address: segment * 16 + offset, modulo 2^20.
    function automatic logic [19:0] phys_addr(input logic [15:0] seg,
                                              input logic [15:0] off);
        return {seg, 4'h0} + {4'h0, off};
    endfunction

    // Stage 1 state
    logic        s1_valid_q, s1_valid_d;
    logic [15:0] s1_ea_q,    s1_ea_d;
    logic        s1_wrap_q,  s1_wrap_d;
    logic [15:0] s1_seg_q,   s1_seg_d;
    // Stage 2 state (drives the outputs directly)
    logic        s2_valid_q, s2_valid_d;
    logic [15:0] s2_ea_q,    s2_ea_d;
    logic [19:0] s2_fis_q,   s2_fis_d;
    logic        s2_wrap_q,  s2_wrap_d;

    // Combinational stage-1 datapath
    logic [15:0] idx_s;
    logic [18:0] dext_s;
    logic [18:0] sum_s;
    logic [15:0] seg_sel_s;
    // Handshake control
    logic        s2_load_s;
    logic        s1_adv_s;
    logic        in_ready_s;
    logic        in_xfer_s;

    // Stage-1 arithmetic: the sum is kept 19 bits wide and signed so that
    // both underflow (bit 18) and overflow (bits 17:16) show up as wrap.
    always_comb begin
        idx_s     = idx_sel(modo, si, di);
        dext_s    = disp_ext(disp, disp8, modo);
        sum_s     = {3'b000, bp} + {3'b000, idx_s} + dext_s;
        seg_sel_s = ss;
        if (seg_ovr_en) begin
            seg_sel_s = seg_ovr;
        end else begin
            seg_sel_s = ss;
        end
    end

    // Pipeline control and next-state for both stages.
    always_comb begin
        s2_load_s  = (~s2_valid_q) | out_ready;
        s1_adv_s   = s1_valid_q & s2_load_s;
        in_ready_s = (~s1_valid_q) | s2_load_s;
        in_xfer_s  = in_valid & in_ready_s;

        s1_valid_d = s1_valid_q;
        s1_ea_d    = s1_ea_q;
        s1_wrap_d  = s1_wrap_q;
        s1_seg_d   = s1_seg_q;
        s2_valid_d = s2_valid_q;
        s2_ea_d    = s2_ea_q;
        s2_fis_d   = s2_fis_q;
        s2_wrap_d  = s2_wrap_q;

        if (in_ready_s) begin
            s1_valid_d = in_xfer_s;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (in_xfer_s) begin
            s1_ea_d   = sum_s[15:0];
            s1_wrap_d = |sum_s[18:16];
            s1_seg_d  = seg_sel_s;
        end else begin
            s1_ea_d   = s1_ea_q;
        end

        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (s1_adv_s) begin
            s2_ea_d   = s1_ea_q;
            s2_fis_d  = phys_addr(s1_seg_q, s1_ea_q);
            s2_wrap_d = s1_wrap_q;
        end else begin
            s2_ea_d   = s2_ea_q;
        end
    end

    // Pipeline registers; reset empties both stages and zeroes the data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_ea_q    <= 16'h0000;
            s1_wrap_q  <= 1'b0;
            s1_seg_q   <= 16'h0000;
            s2_valid_q <= 1'b0;
            s2_ea_q    <= 16'h0000;
            s2_fis_q   <= 20'h00000;
            s2_wrap_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ea_q    <= s1_ea_d;
            s1_wrap_q  <= s1_wrap_d;
            s1_seg_q   <= s1_seg_d;
            s2_valid_q <= s2_valid_d;
            s2_ea_q    <= s2_ea_d;
            s2_fis_q   <= s2_fis_d;
            s2_wrap_q  <= s2_wrap_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_q;
    assign ea        = s2_ea_q;
    assign dir_fis   = s2_fis_q;
    assign ea_wrap   = s2_wrap_q;

endmodule

// File: tb/tb_calc_dir_pila.sv
// Testbench for calc_dir_pila: directed scenarios plus a randomized
// scoreboard run. Inputs change 2 time units after the rising edge; all
// DUT outputs are sampled on the falling edge.
module tb_calc_dir_pila;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  modo;
    logic [15:0] bp, si, di, ss, seg_ovr, disp;
    logic        seg_ovr_en, disp8;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ea;
    logic [19:0] dir_fis;
    logic        ea_wrap;

    typedef struct packed {
        logic [15:0] ea;
        logic [19:0] fis;
        logic        wrap;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    calc_dir_pila dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .modo(modo), .bp(bp), .si(si), .di(di), .ss(ss),
        .seg_ovr_en(seg_ovr_en), .seg_ovr(seg_ovr), .disp(disp), .disp8(disp8),
        .out_valid(out_valid), .out_ready(out_ready),
        .ea(ea), .dir_fis(dir_fis), .ea_wrap(ea_wrap)
    );

    always #5 CLK = ~CLK;

    // Reference model using plain integer arithmetic.
    function automatic exp_t model(input logic [1:0] m, input logic [15:0] b,
                                   input logic [15:0] s, input logic [15:0] d_i,
                                   input logic [15:0] sg, input logic oe,
                                   input logic [15:0] ov, input logic [15:0] dp,
                                   input logic d8);
        int idx, dext, sum, segv, phys;
        logic signed [7:0]  lo;
        logic signed [15:0] full;
        exp_t e;
        lo   = dp[7:0];
        full = dp;
        if (m == 2'b01)      idx = int'(s);
        else if (m == 2'b10) idx = int'(d_i);
        else                 idx = 0;
        if (m == 2'b11)  dext = 0;
        else if (d8)     dext = lo;
        else             dext = full;
        sum    = int'(b) + idx + dext;
        e.ea   = sum[15:0];
        e.wrap = (sum < 0) || (sum > 65535);
        segv   = oe ? int'(ov) : int'(sg);
        phys   = segv * 16 + int'(e.ea);
        e.fis  = phys[19:0];
        return e;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge CLK) begin
        if (RST) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got ea=%h fis=%h wrap=%0b exp=no result", ea, dir_fis, ea_wrap);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if ({ea, dir_fis, ea_wrap} !== {e.ea, e.fis, e.wrap}) begin
                        bad++;
                        $display("FAIL sb_result got ea=%h fis=%h wrap=%0b exp ea=%h fis=%h wrap=%0b",
                                 ea, dir_fis, ea_wrap, e.ea, e.fis, e.wrap);
                    end
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(model(modo, bp, si, di, ss, seg_ovr_en, seg_ovr, disp, disp8));
        end
    end

    task automatic next_cycle;
        @(posedge CLK);
        #2;
    endtask

    task automatic set_req(input logic [1:0] m, input logic [15:0] b,
                           input logic [15:0] s, input logic [15:0] d_i,
                           input logic [15:0] sg, input logic oe,
                           input logic [15:0] ov, input logic [15:0] dp,
                           input logic d8);
        modo = m; bp = b; si = s; di = d_i; ss = sg;
        seg_ovr_en = oe; seg_ovr = ov; disp = dp; disp8 = d8;
    endtask

    task automatic set_rand_req;
        set_req(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                1'($urandom));
    endtask

    // Present one request with no backpressure and stop at the sampling
    // point of the cycle where its result should be visible.
    task automatic run_one(input logic [1:0] m, input logic [15:0] b,
                           input logic [15:0] s, input logic [15:0] d_i,
                           input logic [15:0] sg, input logic oe,
                           input logic [15:0] ov, input logic [15:0] dp,
                           input logic d8);
        next_cycle;
        set_req(m, b, s, d_i, sg, oe, ov, dp, d8);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        next_cycle;
        in_valid = 1'b0;
        next_cycle;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_req(2'b00, 16'h1234, 16'h0000, 16'h0000, 16'h1000, 1'b0,
                16'h0000, 16'h0010, 1'b0);
        next_cycle;
        next_cycle;
        @(negedge CLK);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        total++; if (ea !== 16'h0000) begin bad++; $display("FAIL rst_ea got=%h exp=0000", ea); end
        total++; if (dir_fis !== 20'h00000) begin bad++; $display("FAIL rst_dir_fis got=%h exp=00000", dir_fis); end
        total++; if (ea_wrap !== 1'b0) begin bad++; $display("FAIL rst_ea_wrap got=%0b exp=0", ea_wrap); end
        next_cycle;
        RST = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        next_cycle;
        next_cycle;
        @(negedge CLK);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_accept got out_valid=%0b exp=0", out_valid); end
    endtask

    task automatic test_basic;
        next_cycle;
        set_req(2'b01, 16'h1000, 16'h0020, 16'hAAAA, 16'h2000, 1'b0,
                16'h5555, 16'h0004, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%0b exp=1", in_ready); end
        next_cycle;
        in_valid = 1'b0;
        @(negedge CLK);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early got out_valid=%0b exp=0", out_valid); end
        next_cycle;
        @(negedge CLK);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got out_valid=%0b exp=1", out_valid); end
        total++; if (ea !== 16'h1024) begin bad++; $display("FAIL basic_ea got=%h exp=1024", ea); end
        total++; if (dir_fis !== 20'h21024) begin bad++; $display("FAIL basic_dir_fis got=%h exp=21024", dir_fis); end
        total++; if (ea_wrap !== 1'b0) begin bad++; $display("FAIL basic_wrap got=%0b exp=0", ea_wrap); end
        next_cycle;
        @(negedge CLK);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_single got out_valid=%0b exp=0", out_valid); end
    endtask

    task automatic test_sign_wrap;
        run_one(2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 1'b0,
                16'h0000, 16'h00F0, 1'b1);
        total++; if (ea !== 16'h0000) begin bad++; $display("FAIL sext_ea got=%h exp=0000", ea); end
        total++; if (ea_wrap !== 1'b0) begin bad++; $display("FAIL sext_wrap got=%0b exp=0", ea_wrap); end
        run_one(2'b00, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0,
                16'h0000, 16'h7702, 1'b1);
        total++; if (ea !== 16'h0001) begin bad++; $display("FAIL wrap_ea got=%h exp=0001", ea); end
        total++; if (ea_wrap !== 1'b1) begin bad++; $display("FAIL wrap_flag got=%0b exp=1", ea_wrap); end
    endtask

    task automatic test_seg_ovr;
        run_one(2'b11, 16'h0020, 16'h1111, 16'h2222, 16'h3000, 1'b1,
                16'hFFFF, 16'h8000, 1'b0);
        total++; if (ea !== 16'h0020) begin bad++; $display("FAIL ovr_ea got=%h exp=0020", ea); end
        total++; if (dir_fis !== 20'h00010) begin bad++; $display("FAIL ovr_dir_fis got=%h exp=00010", dir_fis); end
        total++; if (ea_wrap !== 1'b0) begin bad++; $display("FAIL ovr_wrap got=%0b exp=0", ea_wrap); end
    endtask

    task automatic test_back_to_back;
        int cnt = 0;
        int run = 0;
        int maxrun = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next_cycle;
            if (i < 5) begin
                set_rand_req;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge CLK);
            if (i < 5) begin
                total++;
                if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cycle %0d got=%0b exp=1", i, in_ready); end
            end
            if (out_valid === 1'b1) begin
                cnt++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        total++; if (cnt != 5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", cnt); end
        total++; if (maxrun != 5) begin bad++; $display("FAIL b2b_throughput got run=%0d exp=5", maxrun); end
    endtask

    task automatic test_backpressure;
        exp_t ea_a, ea_b, ea_c;
        ea_a = model(2'b01, 16'h0100, 16'h0011, 16'h0000, 16'h1000, 1'b0, 16'h0000, 16'h0001, 1'b0);
        ea_b = model(2'b10, 16'h0200, 16'h0000, 16'h0022, 16'h2000, 1'b0, 16'h0000, 16'h0002, 1'b0);
        ea_c = model(2'b00, 16'h0300, 16'h0000, 16'h0000, 16'h3000, 1'b1, 16'h4000, 16'h0003, 1'b0);
        next_cycle;
        set_req(2'b01, 16'h0100, 16'h0011, 16'h0000, 16'h1000, 1'b0, 16'h0000, 16'h0001, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge CLK);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_a got in_ready=%0b exp=1", in_ready); end
        next_cycle;
        set_req(2'b10, 16'h0200, 16'h0000, 16'h0022, 16'h2000, 1'b0, 16'h0000, 16'h0002, 1'b0);
        @(negedge CLK);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_b got in_ready=%0b exp=1", in_ready); end
        next_cycle;
        set_req(2'b00, 16'h0300, 16'h0000, 16'h0000, 16'h3000, 1'b1, 16'h4000, 16'h0003, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got in_ready=%0b exp=0", in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%0b exp=1", out_valid); end
            total++; if ({ea, dir_fis, ea_wrap} !== {ea_a.ea, ea_a.fis, ea_a.wrap}) begin
                bad++; $display("FAIL bp_hold_a got ea=%h fis=%h exp ea=%h fis=%h", ea, dir_fis, ea_a.ea, ea_a.fis);
            end
            if (k == 0) next_cycle;
        end
        next_cycle;
        out_ready = 1'b1;
        @(negedge CLK);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got in_ready=%0b exp=1", in_ready); end
        total++; if (ea !== ea_a.ea) begin bad++; $display("FAIL bp_order_a got=%h exp=%h", ea, ea_a.ea); end
        next_cycle;
        in_valid = 1'b0;
        @(negedge CLK);
        total++; if (out_valid !== 1'b1 || ea !== ea_b.ea) begin bad++; $display("FAIL bp_order_b got v=%0b ea=%h exp v=1 ea=%h", out_valid, ea, ea_b.ea); end
        next_cycle;
        @(negedge CLK);
        total++; if (out_valid !== 1'b1 || ea !== ea_c.ea || dir_fis !== ea_c.fis) begin
            bad++; $display("FAIL bp_order_c got v=%0b ea=%h fis=%h exp v=1 ea=%h fis=%h", out_valid, ea, dir_fis, ea_c.ea, ea_c.fis);
        end
        next_cycle;
        @(negedge CLK);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got out_valid=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_flush;
        next_cycle;
        out_ready = 1'b0;
        set_req(2'b01, 16'h4000, 16'h0100, 16'h0000, 16'h1000, 1'b0, 16'h0000, 16'h0010, 1'b0);
        in_valid = 1'b1;
        next_cycle;
        set_req(2'b10, 16'h5000, 16'h0000, 16'h0200, 16'h2000, 1'b0, 16'h0000, 16'h0020, 1'b0);
        next_cycle;
        RST = 1'b1;
        out_ready = 1'b1;
        set_req(2'b11, 16'h6000, 16'h0000, 16'h0000, 16'h3000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        next_cycle;
        RST = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        total++; if ({ea, dir_fis, ea_wrap} !== 37'h0) begin bad++; $display("FAIL flush_zero got ea=%h fis=%h wrap=%0b exp=0", ea, dir_fis, ea_wrap); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            next_cycle;
            @(negedge CLK);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost cycle %0d got out_valid=%0b exp=0", k, out_valid); end
        end
    endtask

    task automatic test_random;
        int waited = 0;
        for (int i = 0; i < 120; i++) begin
            next_cycle;
            set_rand_req;
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        next_cycle;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        while (sb_q.size() != 0 && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL rand_drain got pending=%0d exp=0", sb_q.size()); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_req(2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        test_reset;
        test_basic;
        test_sign_wrap;
        test_seg_ovr;
        test_back_to_back;
        test_backpressure;
        test_reset_flush;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
